// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Imported by the top-level datapath and its testbench.
package nibble_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-nibble adder still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bit_4_cla.sv
// 4-bit carry-lookahead adder slice.
// Pure combinational; the serial wrapper reuses it for every nibble.
module bit_4_cla (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    always_comb begin
        p = a ^ b;
        g = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that streams one nibble per clock through a single
// bit_4_cla, registering the carry between nibbles.
module nibble_serial_adder
    import nibble_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]   a,
    input  logic [NIBBLE_W*NIBBLES-1:0]   b,
    input  logic                          cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]   sum,
    output logic                          cout,
    output logic                          overflow
);

    localparam int IW = idx_width(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] vec_t;

    state_e          state_q, state_d;
    vec_t            a_q, a_d;
    vec_t            b_q, b_d;
    vec_t            sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] cla_a;
    logic [NIBBLE_W-1:0] cla_b;
    logic [NIBBLE_W-1:0] cla_sum;
    logic                cla_cout;
    logic                is_last;

    bit_4_cla u_cla (
        .a    (cla_a),
        .b    (cla_b),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid)  state_d = RUN;
            RUN:  if (is_last)   state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Nibble mux: loop compare keeps index widths exact for any NIBBLES.
    always_comb begin
        cla_a = '0;
        cla_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                cla_a = a_q[i];
                cla_b = b_q[i];
            end
        end
        is_last = (state_q == RUN) && (idx_q == LAST);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && in_valid) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
            sum_d   = '0;
        end else if (state_q == RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx_q == IW'(i)) begin
                    sum_d[i] = cla_sum;
                end
            end
            carry_d = cla_cout;
            if (is_last) begin
                idx_d  = '0;
                cout_d = cla_cout;
                // Carry into the sign bit differs from carry out of it.
                ovf_d  = a_q[NIBBLES-1][NIBBLE_W-1]
                       ^ b_q[NIBBLES-1][NIBBLE_W-1]
                       ^ cla_sum[NIBBLE_W-1]
                       ^ cla_cout;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at NIBBLES = 4, 1 and 16.
// Vector table plus random operands, scored through an expectation queue.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  iv;
    logic [2:0]  ordy;
    logic [2:0]  cv;
    logic [63:0] av [3];
    logic [63:0] bv [3];
    wire  [2:0]  irdy;
    wire  [2:0]  ov;
    wire  [2:0]  co;
    wire  [2:0]  of;
    wire  [15:0] s4;
    wire  [3:0]  s1;
    wire  [63:0] s16;

    nibble_serial_adder #(.NIBBLES(4)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(av[0][15:0]), .b(bv[0][15:0]), .cin(cv[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(s4), .cout(co[0]), .overflow(of[0])
    );

    nibble_serial_adder #(.NIBBLES(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(av[1][3:0]), .b(bv[1][3:0]), .cin(cv[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(s1), .cout(co[1]), .overflow(of[1])
    );

    nibble_serial_adder #(.NIBBLES(16)) u16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2]), .in_ready(irdy[2]),
        .a(av[2]), .b(bv[2]), .cin(cv[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]),
        .sum(s16), .cout(co[2]), .overflow(of[2])
    );

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] s;
        logic        c;
        logic        o;
    } vec_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    function automatic int nib(input int d);
        return (d == 0) ? 4 : (d == 1) ? 1 : 16;
    endfunction

    function automatic logic [63:0] sumv(input int d);
        if (d == 0) return {48'd0, s4};
        if (d == 1) return {60'd0, s1};
        return s16;
    endfunction

    function automatic logic [63:0] mask(input int d);
        int w;
        w = 4 * nib(d);
        return (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model(input int d, input logic [63:0] a, b,
                         input logic cin, output logic [63:0] s,
                         output logic c, output logic o);
        logic [64:0] full;
        int w;
        w = 4 * nib(d);
        full = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        s = full[63:0] & mask(d);
        c = full[w];
        o = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    endtask

    task automatic run_op(input int d, input logic [63:0] a, b,
                          input logic cin, input logic [63:0] es,
                          input logic ec, eo, input bit noisy,
                          input int hold);
        exp_t e;
        int lat;
        logic [63:0] held;
        @(negedge clk);
        chk("in_ready_idle", {63'd0, irdy[d]}, 64'd1);
        iv[d] = 1'b1;
        av[d] = a;
        bv[d] = b;
        cv[d] = cin;
        sb.push_back('{s: es, c: ec, o: eo});
        @(negedge clk);
        iv[d] = 1'b0;
        lat = 0;
        while (!ov[d] && lat < 64) begin
            if (noisy) begin
                iv[d] = ~iv[d];
                av[d] = ~av[d];
                bv[d] = {$urandom, $urandom};
                cv[d] = ~cv[d];
                chk("in_ready_run", {63'd0, irdy[d]}, 64'd0);
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(nib(d)));
        e = sb.pop_front();
        chk("sum", sumv(d), e.s);
        chk("cout", {63'd0, co[d]}, {63'd0, e.c});
        chk("overflow", {63'd0, of[d]}, {63'd0, e.o});
        held = sumv(d);
        repeat (hold) begin
            iv[d] = ~iv[d];
            av[d] = ~av[d];
            @(negedge clk);
            chk("hold_valid", {63'd0, ov[d]}, 64'd1);
            chk("hold_sum", sumv(d), held);
            chk("hold_in_ready", {63'd0, irdy[d]}, 64'd0);
        end
        iv[d] = 1'b0;
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
        chk("in_ready_after", {63'd0, irdy[d]}, 64'd1);
        chk("out_valid_after", {63'd0, ov[d]}, 64'd0);
    endtask

    vec_t tbl[$];

    initial begin
        logic [63:0] ra, rb, es;
        logic rc, ec, eo;

        iv = '0;
        ordy = '0;
        cv = '0;
        for (int i = 0; i < 3; i++) begin
            av[i] = '0;
            bv[i] = '0;
        end

        tbl.push_back('{64'hFFFF, 64'h0001, 1'b0, 64'h0000, 1'b1, 1'b0});
        tbl.push_back('{64'h7FFF, 64'h0001, 1'b0, 64'h8000, 1'b0, 1'b1});
        tbl.push_back('{64'h8000, 64'h8000, 1'b0, 64'h0000, 1'b1, 1'b1});
        tbl.push_back('{64'h1234, 64'h4321, 1'b1, 64'h5556, 1'b0, 1'b0});
        tbl.push_back('{64'h0000, 64'h0000, 1'b1, 64'h0001, 1'b0, 1'b0});
        tbl.push_back('{64'hFFFF, 64'hFFFF, 1'b1, 64'hFFFF, 1'b1, 1'b0});
        tbl.push_back('{64'h8000, 64'hFFFF, 1'b0, 64'h7FFF, 1'b1, 1'b1});

        repeat (2) @(negedge clk);
        chk("rst_in_ready", {63'd0, irdy[0]}, 64'd1);
        chk("rst_out_valid", {63'd0, ov[0]}, 64'd0);
        chk("rst_sum", sumv(0), 64'd0);
        chk("rst_cout", {63'd0, co[0]}, 64'd0);
        chk("rst_ovf", {63'd0, of[0]}, 64'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_op(0, tbl[i].a, tbl[i].b, tbl[i].cin,
                   tbl[i].s, tbl[i].c, tbl[i].o, 1'b0, 0);
        end

        run_op(0, 64'h1234, 64'h4321, 1'b1, 64'h5556, 1'b0, 1'b0,
               1'b1, 5);

        @(negedge clk);
        iv[0] = 1'b1;
        av[0] = 64'hAAAA;
        bv[0] = 64'h5555;
        cv[0] = 1'b0;
        sb.push_back('{s: 64'hFFFF, c: 1'b0, o: 1'b0});
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_in_ready", {63'd0, irdy[0]}, 64'd1);
        chk("midrst_out_valid", {63'd0, ov[0]}, 64'd0);
        chk("midrst_sum", sumv(0), 64'd0);
        chk("midrst_cout", {63'd0, co[0]}, 64'd0);
        chk("midrst_ovf", {63'd0, of[0]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 64'h0003, 64'h0004, 1'b0, 64'h0007, 1'b0, 1'b0,
               1'b0, 0);

        run_op(1, 64'hF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 0);
        run_op(1, 64'h7, 64'h1, 1'b0, 64'h8, 1'b0, 1'b1, 1'b0, 0);
        run_op(2, '1, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 0);
        run_op(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 0);

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < ((d == 0) ? 1000 : 40); n++) begin
                ra = {$urandom, $urandom} & mask(d);
                rb = {$urandom, $urandom} & mask(d);
                rc = 1'($urandom);
                model(d, ra, rb, rc, es, ec, eo);
                run_op(d, ra, rb, rc, es, ec, eo, 1'b0, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

- Multi-nibble, bit-serial-by-nibble adder of width 4·NIBBLES.
- Operands are accepted once through a valid/ready handshake, one 4-bit nibble per clock is streamed through the existing `bit_4_cla` carry-lookahead adder, and the carry is registered between nibbles.
- The full sum, carry-out and signed overflow are presented through a second valid/ready handshake.
- Sits directly around `bit_4_cla`: it feeds the adder's a/b/cin inputs and consumes its sum/cout outputs, turning the combinational 4-bit stage into a wide sequential datapath.

## Interface
- NIBBLES, 4, number of 4-bit slices; operand width W = 4·NIBBLES; legal range 1..16
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands
- a  input  W  operand A, unsigned or two's complement
- b  input  W  operand B
- cin  input  1  carry into nibble 0
- out_valid  output  1  sum, cout, overflow are valid
- out_ready  input  1  consumer accepts the result
- sum  output  W  result, registered
- cout  output  1  carry out of bit W-1, registered
- overflow  output  1  signed overflow flag, registered

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a, b into operand registers, set carry_r=cin, idx=0, clear the sum register, go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, drive `bit_4_cla` with a_r[4·idx+:4], b_r[4·idx+:4] and carry_r.
  - On the clock edge, write its sum into sum_r[4·idx+:4], set carry_r <= cout and idx <= idx+1.
  - When idx==NIBBLES-1, the same edge sets cout_r <= cla cout and overflow_r <= a_r[W-1] ^ b_r[W-1] ^ cla_sum[3] ^ cla_cout, then goes to DONE.
- DONE:
  - out_valid=1; sum, cout and overflow are held stable.
  - On out_valid&&out_ready, go to IDLE.
  - in_ready stays 0 in DONE, so no same-cycle accept on the result handshake.
- in_valid, a, b and cin are ignored outside IDLE. Operand changes during RUN have no effect.
- Arithmetic: the result equals (a+b+cin) mod 2^W, and cout equals bit W of the full sum.
- overflow is 1 iff a[W-1]==b[W-1] and sum[W-1]!=a[W-1].
- idx width is max(1, $clog2(NIBBLES)). idx never exceeds NIBBLES-1.
- NIBBLES=1: RUN lasts exactly one cycle.

## Timing
- Reset (asynchronous assertion, takes effect immediately):
  - State returns to IDLE.
  - in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, idx=0, carry_r=0.
  - Reset mid-RUN or mid-DONE discards the operation; no partial result is ever presented.
- Deassertion is synchronous to clk.
- Latency:
  - Accept edge E0.
  - RUN occupies the cycles after E0 and completes at edge E_NIBBLES.
  - out_valid is high starting in the cycle after E_NIBBLES, so it rises NIBBLES cycles after acceptance.
- Result-handshake edge Ek returns the block to IDLE; in_ready is 1 in the following cycle.
- Minimum period between accepts is NIBBLES+2 cycles.
- sum bits of nibbles not yet processed read 0 during RUN. out_valid gates their use.
- All outputs are registered; no combinational path from inputs to outputs. in_ready and out_valid decode the state register only.
- Back-pressure: out_ready low holds DONE indefinitely with outputs unchanged.

## Structure
- Shared package `nibble_adder_pkg`:
  - state enum {IDLE, RUN, DONE}
  - localparam NIBBLE_W=4
  - function computing idx width
- One sub-module: the existing `bit_4_cla` (ports a, b, cin, sum, cout), instantiated once and time-multiplexed across nibbles.
- Top contains the FSM, operand/sum/carry registers and the nibble mux/demux.

## Test plan
- NIBBLES=4, a=0xFFFF, b=0x0001, cin=0 -> exactly 4 cycles after accept: sum=0x0000, cout=1, overflow=0.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1. a=0x8000, b=0x8000 -> sum=0x0000, cout=1, overflow=1.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, overflow=0. Randomised 1000 operands checked against a+b+cin.
- Back-pressure and ignored inputs:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and sum is stable.
  - Toggle in_valid and a during RUN/DONE -> in_ready=0 and the result is unaffected.
  - After the result handshake, in_ready=1 the next cycle.
- Reset mid-operation: assert rst_n=0 at RUN idx=2 -> immediately in_ready=1, out_valid=0, sum=0, cout=0, overflow=0. The next operation (0x0003+0x0004) yields 0x0007.
- Width corners:
  - NIBBLES=1, a=0xF, b=0x1 -> sum=0x0 and cout=1 one cycle after accept.
  - NIBBLES=16: 64-bit all-ones + 1 -> sum=0, cout=1 after 16 cycles.
